// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM encodings, default frame
// geometry and the idle level of the serial line.
package uart_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  localparam int   DEFAULT_DWL        = 8;
  localparam int   DEFAULT_OVERSAMPLE = 16;
  localparam logic LINE_IDLE          = 1'b1;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line; both stages reset to
// RESET_VAL so the receiver sees an idle line while in reset.
module uart_rx_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic CLK,
  input  logic RST,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge CLK) begin
    if (RST) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: finds the start edge, samples each bit at its
// mid-point, and emits LSB-first words with one-cycle VALID/FRAME_ERR pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DWL        = DEFAULT_DWL,
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           EN,
  input  logic           serialIn,
  output logic [DWL-1:0] parallelData,
  output logic           VALID,
  output logic           FRAME_ERR,
  output logic           BUSY
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = (DWL > 1) ? $clog2(DWL) : 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  // Entry into START already consumed one tick, so the mid-point is two short of half.
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 2);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DWL - 1);

  state_t         state;
  logic           rx_s;
  logic           armed;
  logic [TW-1:0]  tick_cnt;
  logic [BW-1:0]  bit_cnt;
  logic [DWL-1:0] shift_reg;

  uart_rx_sync #(
    .RESET_VAL(LINE_IDLE)
  ) u_sync (
    .CLK(CLK),
    .RST(RST),
    .d  (serialIn),
    .q  (rx_s)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= S_IDLE;
      armed        <= 1'b0;
      tick_cnt     <= '0;
      bit_cnt      <= '0;
      shift_reg    <= '0;
      parallelData <= '0;
      VALID        <= 1'b0;
      FRAME_ERR    <= 1'b0;
      BUSY         <= 1'b0;
    end else begin
      VALID     <= 1'b0;
      FRAME_ERR <= 1'b0;
      BUSY      <= (state != S_IDLE);
      if (EN) begin
        case (state)
          S_IDLE: begin
            if (rx_s == LINE_IDLE) begin
              armed <= 1'b1;
            end else if (armed) begin
              state    <= S_START;
              tick_cnt <= '0;
              armed    <= 1'b0;
            end
          end
          S_START: begin
            if (tick_cnt == TICK_MID) begin
              tick_cnt <= '0;
              bit_cnt  <= '0;
              state    <= (rx_s == LINE_IDLE) ? S_IDLE : S_DATA;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          S_DATA: begin
            if (tick_cnt == TICK_LAST) begin
              tick_cnt  <= '0;
              shift_reg <= {rx_s, shift_reg[DWL-1:1]};
              bit_cnt   <= bit_cnt + 1'b1;
              if (bit_cnt == BIT_LAST) begin
                state <= S_STOP;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          S_STOP: begin
            if (tick_cnt == TICK_LAST) begin
              tick_cnt <= '0;
              state    <= S_IDLE;
              // A high stop sample doubles as the re-arm sample for back-to-back frames.
              if (rx_s == LINE_IDLE) begin
                parallelData <= shift_reg;
                VALID        <= 1'b1;
                armed        <= 1'b1;
              end else begin
                FRAME_ERR <= 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: EN every 4 clocks, 16x oversampling, so one bit
// lasts 64 clocks; a negedge monitor tallies output pulses for the test tasks.
module tb_uart_rx;

  localparam int BIT_CLKS = 64;

  logic       CLK;
  logic       RST;
  logic       EN;
  logic       serialIn;
  logic [7:0] parallelData;
  logic       VALID;
  logic       FRAME_ERR;
  logic       BUSY;

  int errors = 0;
  int checks = 0;

  int         validCount = 0;
  int         errCount   = 0;
  int         validLong  = 0;
  int         errLong    = 0;
  int         bothHigh   = 0;
  logic       prevValid  = 1'b0;
  logic       prevErr    = 1'b0;
  logic [7:0] dataLog [16];

  uart_rx #(
    .DWL(8),
    .OVERSAMPLE(16)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .EN          (EN),
    .serialIn    (serialIn),
    .parallelData(parallelData),
    .VALID       (VALID),
    .FRAME_ERR   (FRAME_ERR),
    .BUSY        (BUSY)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    int cnt;
    cnt = 0;
    EN  = 1'b0;
    forever begin
      @(negedge CLK);
      cnt = (cnt + 1) % 4;
      EN  = (cnt == 0);
    end
  end

  always @(negedge CLK) begin
    if (VALID) begin
      if (validCount < 16) dataLog[validCount] = parallelData;
      validCount++;
    end
    if (FRAME_ERR) errCount++;
    if (VALID && prevValid) validLong++;
    if (FRAME_ERR && prevErr) errLong++;
    if (VALID && FRAME_ERR) bothHigh++;
    prevValid = VALID;
    prevErr   = FRAME_ERR;
  end

  task automatic sendFrame(input logic [7:0] data, input logic stopBit);
    serialIn = 1'b0;
    repeat (BIT_CLKS) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      serialIn = data[i];
      repeat (BIT_CLKS) @(negedge CLK);
    end
    serialIn = stopBit;
    repeat (BIT_CLKS) @(negedge CLK);
  endtask

  task automatic test_reset;
    RST      = 1'b1;
    serialIn = 1'b1;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    checks++;
    if (parallelData !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_data: got %h expected 00", parallelData);
    end
    checks++;
    if (VALID !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_valid: got %b expected 0", VALID);
    end
    checks++;
    if (FRAME_ERR !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_frame_err: got %b expected 0", FRAME_ERR);
    end
    checks++;
    if (BUSY !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_busy: got %b expected 0", BUSY);
    end
    repeat (2 * BIT_CLKS) @(negedge CLK);
  endtask

  task automatic test_single_frame;
    int v0;
    int e0;
    v0 = validCount;
    e0 = errCount;
    sendFrame(8'hA5, 1'b1);
    checks++;
    if (validCount !== v0 + 1) begin
      errors++;
      $display("[TB] FAIL a5_valid_count: got %0d expected %0d", validCount, v0 + 1);
    end
    checks++;
    if (dataLog[v0] !== 8'hA5) begin
      errors++;
      $display("[TB] FAIL a5_data_at_valid: got %h expected a5", dataLog[v0]);
    end
    checks++;
    if (parallelData !== 8'hA5) begin
      errors++;
      $display("[TB] FAIL a5_data_held: got %h expected a5", parallelData);
    end
    checks++;
    if (errCount !== e0) begin
      errors++;
      $display("[TB] FAIL a5_no_frame_err: got %0d expected %0d", errCount, e0);
    end
    checks++;
    if (validLong !== 0) begin
      errors++;
      $display("[TB] FAIL a5_valid_width: got %0d long pulses expected 0", validLong);
    end
    checks++;
    if (BUSY !== 1'b0) begin
      errors++;
      $display("[TB] FAIL a5_busy_after: got %b expected 0", BUSY);
    end
    repeat (BIT_CLKS) @(negedge CLK);
  endtask

  task automatic test_glitch;
    int v0;
    int e0;
    v0 = validCount;
    e0 = errCount;
    serialIn = 1'b0;
    repeat (16) @(negedge CLK);
    checks++;
    if (BUSY !== 1'b1) begin
      errors++;
      $display("[TB] FAIL glitch_busy_start: got %b expected 1", BUSY);
    end
    serialIn = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge CLK);
    checks++;
    if (BUSY !== 1'b0) begin
      errors++;
      $display("[TB] FAIL glitch_busy_idle: got %b expected 0", BUSY);
    end
    checks++;
    if (validCount !== v0) begin
      errors++;
      $display("[TB] FAIL glitch_no_valid: got %0d expected %0d", validCount, v0);
    end
    checks++;
    if (errCount !== e0) begin
      errors++;
      $display("[TB] FAIL glitch_no_frame_err: got %0d expected %0d", errCount, e0);
    end
    checks++;
    if (parallelData !== 8'hA5) begin
      errors++;
      $display("[TB] FAIL glitch_data_kept: got %h expected a5", parallelData);
    end
  endtask

  task automatic test_frame_error;
    int v0;
    int e0;
    int busySeen;
    v0 = validCount;
    e0 = errCount;
    busySeen = 0;
    sendFrame(8'h3C, 1'b0);
    serialIn = 1'b0;
    for (int i = 0; i < 3 * BIT_CLKS; i++) begin
      @(negedge CLK);
      if (BUSY) busySeen++;
    end
    checks++;
    if (errCount !== e0 + 1) begin
      errors++;
      $display("[TB] FAIL ferr_count: got %0d expected %0d", errCount, e0 + 1);
    end
    checks++;
    if (errLong !== 0) begin
      errors++;
      $display("[TB] FAIL ferr_width: got %0d long pulses expected 0", errLong);
    end
    checks++;
    if (validCount !== v0) begin
      errors++;
      $display("[TB] FAIL ferr_no_valid: got %0d expected %0d", validCount, v0);
    end
    checks++;
    if (parallelData !== 8'hA5) begin
      errors++;
      $display("[TB] FAIL ferr_data_kept: got %h expected a5", parallelData);
    end
    checks++;
    if (busySeen !== 0) begin
      errors++;
      $display("[TB] FAIL ferr_no_retrigger: got %0d busy cycles expected 0", busySeen);
    end
    serialIn = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge CLK);
  endtask

  task automatic test_back_to_back;
    int v0;
    v0 = validCount;
    sendFrame(8'h00, 1'b1);
    sendFrame(8'hFF, 1'b1);
    serialIn = 1'b1;
    repeat (BIT_CLKS) @(negedge CLK);
    checks++;
    if (validCount !== v0 + 2) begin
      errors++;
      $display("[TB] FAIL b2b_valid_count: got %0d expected %0d", validCount, v0 + 2);
    end
    checks++;
    if (dataLog[v0] !== 8'h00) begin
      errors++;
      $display("[TB] FAIL b2b_first_data: got %h expected 00", dataLog[v0]);
    end
    checks++;
    if (dataLog[v0 + 1] !== 8'hFF) begin
      errors++;
      $display("[TB] FAIL b2b_second_data: got %h expected ff", dataLog[v0 + 1]);
    end
    checks++;
    if (bothHigh !== 0 || validLong !== 0) begin
      errors++;
      $display("[TB] FAIL b2b_pulse_shape: got both=%0d long=%0d expected 0/0", bothHigh, validLong);
    end
  endtask

  task automatic test_reset_midframe;
    logic [7:0] word;
    int v0;
    int e0;
    word = 8'h5A;
    v0 = validCount;
    e0 = errCount;
    serialIn = 1'b0;
    repeat (BIT_CLKS) @(negedge CLK);
    for (int i = 0; i < 4; i++) begin
      serialIn = word[i];
      repeat (BIT_CLKS) @(negedge CLK);
    end
    serialIn = word[4];
    repeat (BIT_CLKS / 2) @(negedge CLK);
    checks++;
    if (BUSY !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_busy_before_reset: got %b expected 1", BUSY);
    end
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    checks++;
    if (parallelData !== 8'h00 || VALID !== 1'b0 || FRAME_ERR !== 1'b0 || BUSY !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_reset_outputs: got data=%h v=%b fe=%b busy=%b expected all 0",
               parallelData, VALID, FRAME_ERR, BUSY);
    end
    serialIn = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge CLK);
    checks++;
    if (validCount !== v0 || errCount !== e0) begin
      errors++;
      $display("[TB] FAIL mid_abandoned: got v=%0d fe=%0d expected %0d/%0d", validCount, errCount, v0, e0);
    end
    sendFrame(8'h81, 1'b1);
    serialIn = 1'b1;
    repeat (BIT_CLKS) @(negedge CLK);
    checks++;
    if (validCount !== v0 + 1) begin
      errors++;
      $display("[TB] FAIL mid_next_valid: got %0d expected %0d", validCount, v0 + 1);
    end
    checks++;
    if (parallelData !== 8'h81) begin
      errors++;
      $display("[TB] FAIL mid_next_data: got %h expected 81", parallelData);
    end
  endtask

  task automatic test_stuck_low;
    int v0;
    int e0;
    int busySeen;
    int tries;
    v0 = validCount;
    e0 = errCount;
    busySeen = 0;
    tries = 0;
    serialIn = 1'b0;
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    // Release just after an EN tick so the synchroniser's reset-high value drains before the next tick.
    do begin
      @(posedge CLK);
      tries++;
    end while (!EN && tries < 8);
    @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < 20 * BIT_CLKS; i++) begin
      @(negedge CLK);
      if (BUSY) busySeen++;
    end
    checks++;
    if (busySeen !== 0) begin
      errors++;
      $display("[TB] FAIL stuck_busy: got %0d busy cycles expected 0", busySeen);
    end
    checks++;
    if (validCount !== v0) begin
      errors++;
      $display("[TB] FAIL stuck_no_valid: got %0d expected %0d", validCount, v0);
    end
    checks++;
    if (errCount !== e0) begin
      errors++;
      $display("[TB] FAIL stuck_no_frame_err: got %0d expected %0d", errCount, e0);
    end
    serialIn = 1'b1;
    repeat (BIT_CLKS) @(negedge CLK);
  endtask

  initial begin
    RST      = 1'b1;
    serialIn = 1'b1;
    test_reset();
    test_single_frame();
    test_glitch();
    test_frame_error();
    test_back_to_back();
    test_reset_midframe();
    test_stuck_low();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
